// File: rtl/micro_seq_pkg.sv
// Shared definitions for the microprogrammed sequencer.
//   NS_W     : width of the microword next-address op field
//   ns_op_e  : next-address op encodings carried in the microword
package micro_seq_pkg;

  localparam int NS_W = 3;

  typedef enum logic [NS_W-1:0] {
    NS_FETCH    = 3'd0,  // go to the fetch state
    NS_DISPATCH = 3'd1,  // go to the decoded IR target
    NS_INC      = 3'd2,  // fall through to state+1
    NS_BR       = 3'd3,  // sts ? cr : state+1
    NS_WAIT     = 3'd4,  // sts ? cr : hold (wait loop)
    NS_CALL     = 3'd5,  // sts ? push state+1, go cr : state+1
    NS_RET      = 3'd6,  // pop and go to popped address
    NS_DBR      = 3'd7   // sts ? dispatch : cr
  } ns_op_e;

endpackage

// File: rtl/micro_call_stack.sv
// LIFO return-address stack for micro-subroutine calls.
//   clk, reset(active-low async) : clock / reset (reset empties the stack)
//   push, push_data              : push request and return address
//   pop                          : pop request
//   top                          : most recent entry (0 when empty)
//   sp                           : occupancy 0..DEPTH
//   full, empty                  : occupancy status
// A push while full or a pop while empty is ignored here; the caller
// decides how to flag it.
module micro_call_stack #(
  parameter int DEPTH = 4,
  parameter int DW    = 7,
  parameter int PW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] push_data,
  output logic [DW-1:0] top,
  output logic [PW-1:0] sp,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] sp_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (sp_q == PW'(DEPTH));
  assign empty   = (sp_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty & ~push;
  assign sp      = sp_q;
  assign top     = empty ? '0 : mem[AW'(sp_q - 1'b1)];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q <= '0;
    end else if (do_push) begin
      sp_q <= sp_q + 1'b1;
    end else if (do_pop) begin
      sp_q <= sp_q - 1'b1;
    end
  end

  // Contents need no reset: sp alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[AW'(sp_q)] <= push_data;
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Parametrised microprogrammed sequencer.
//   clk, reset(active-low async), stall : clock / reset / freeze
//   cond_in       : condition sources selected by the microword
//   dispatch_addr : decoded IR target state
//   mw_*          : microword fields read at ustore_addr
//   ustore_addr   : combinational next-state address to the microstore
//   ctrl          : registered control word of the current state
//   active_state  : registered current state
//   sp            : call-stack occupancy
//   stk_ovf/unf   : sticky stack overflow / underflow flags
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter  int SW          = 7,
  parameter  int CW          = 44,
  parameter  int NCOND       = 4,
  parameter  int STACK_DEPTH = 4,
  parameter  int FETCH_ADDR  = 1,
  parameter  int RESET_ADDR  = 0,
  localparam int CSW         = (NCOND > 1) ? $clog2(NCOND) : 1,
  localparam int SPW         = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [NCOND-1:0] cond_in,
  input  logic [SW-1:0]    dispatch_addr,
  input  logic [CW-1:0]    mw_ctrl,
  input  logic [SW-1:0]    mw_cr,
  input  logic             mw_inv,
  input  logic [CSW-1:0]   mw_sel,
  input  logic [NS_W-1:0]  mw_n,
  output logic [SW-1:0]    ustore_addr,
  output logic [CW-1:0]    ctrl,
  output logic [SW-1:0]    active_state,
  output logic [SPW-1:0]   sp,
  output logic             stk_ovf,
  output logic             stk_unf
);

  logic [SW-1:0]  cr_q;
  logic           inv_q;
  logic [CSW-1:0] sel_q;
  ns_op_e         n_q;

  logic           cond_val;
  logic           sts;
  logic [SW-1:0]  inc;
  logic [SW-1:0]  next_addr;
  logic [SW-1:0]  stk_top;
  logic           stk_full;
  logic           stk_empty;
  logic           push_req;
  logic           pop_req;
  logic           ovf_set;
  logic           unf_set;

  // Out-of-range selects read as a false condition before inversion.
  always_comb begin
    cond_val = 1'b0;
    if (32'(sel_q) < NCOND) begin
      cond_val = cond_in[sel_q];
    end
  end

  assign sts = cond_val ^ inv_q;
  assign inc = active_state + 1'b1;

  always_comb begin
    next_addr = active_state;
    push_req  = 1'b0;
    pop_req   = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    if (!stall) begin
      case (n_q)
        NS_FETCH:    next_addr = SW'(FETCH_ADDR);
        NS_DISPATCH: next_addr = dispatch_addr;
        NS_INC:      next_addr = inc;
        NS_BR:       next_addr = sts ? cr_q : inc;
        NS_WAIT:     next_addr = sts ? cr_q : active_state;
        NS_CALL: begin
          if (sts) begin
            // A call on a full stack still branches; only the return is lost.
            next_addr = cr_q;
            if (stk_full) ovf_set = 1'b1;
            else          push_req = 1'b1;
          end else begin
            next_addr = inc;
          end
        end
        NS_RET: begin
          if (stk_empty) begin
            next_addr = SW'(FETCH_ADDR);
            unf_set   = 1'b1;
          end else begin
            next_addr = stk_top;
            pop_req   = 1'b1;
          end
        end
        NS_DBR:      next_addr = sts ? dispatch_addr : cr_q;
        default:     next_addr = SW'(FETCH_ADDR);
      endcase
    end
  end

  assign ustore_addr = next_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_state <= SW'(RESET_ADDR);
      ctrl         <= '0;
      cr_q         <= '0;
      inv_q        <= 1'b0;
      sel_q        <= '0;
      n_q          <= NS_FETCH;
      stk_ovf      <= 1'b0;
      stk_unf      <= 1'b0;
    end else if (!stall) begin
      active_state <= next_addr;
      ctrl         <= mw_ctrl;
      cr_q         <= mw_cr;
      inv_q        <= mw_inv;
      sel_q        <= mw_sel;
      n_q          <= ns_op_e'(mw_n);
      if (ovf_set) stk_ovf <= 1'b1;
      if (unf_set) stk_unf <= 1'b1;
    end
  end

  micro_call_stack #(
    .DEPTH (STACK_DEPTH),
    .DW    (SW),
    .PW    (SPW)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .pop       (pop_req),
    .push_data (inc),
    .top       (stk_top),
    .sp        (sp),
    .full      (stk_full),
    .empty     (stk_empty)
  );

endmodule

// File: tb/tb_micro_sequencer.sv
module tb_micro_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT 1: default parameters
  logic        rst1 = 1'b0;
  logic        stall1 = 1'b0;
  logic [3:0]  cond1 = '0;
  logic [6:0]  disp1 = '0;
  logic [43:0] mw_ctrl1;
  logic [6:0]  mw_cr1;
  logic        mw_inv1;
  logic [1:0]  mw_sel1;
  logic [2:0]  mw_n1;
  logic [6:0]  ua1;
  logic [43:0] ctrl1;
  logic [6:0]  st1;
  logic [2:0]  sp1;
  logic        ovf1, unf1;

  // DUT 2: SW=4, CW=8, STACK_DEPTH=2
  logic        rst2 = 1'b0;
  logic        stall2 = 1'b0;
  logic        force2 = 1'b0;
  logic [3:0]  cond2 = '0;
  logic [3:0]  disp2 = '0;
  logic [7:0]  mw_ctrl2;
  logic [3:0]  mw_cr2;
  logic        mw_inv2;
  logic [1:0]  mw_sel2;
  logic [2:0]  mw_n2;
  logic [3:0]  ua2;
  logic [7:0]  ctrl2;
  logic [3:0]  st2;
  logic [1:0]  sp2;
  logic        ovf2, unf2;

  micro_sequencer dut1 (
    .clk(clk), .reset(rst1), .stall(stall1), .cond_in(cond1), .dispatch_addr(disp1),
    .mw_ctrl(mw_ctrl1), .mw_cr(mw_cr1), .mw_inv(mw_inv1), .mw_sel(mw_sel1), .mw_n(mw_n1),
    .ustore_addr(ua1), .ctrl(ctrl1), .active_state(st1), .sp(sp1),
    .stk_ovf(ovf1), .stk_unf(unf1)
  );

  micro_sequencer #(.SW(4), .CW(8), .NCOND(4), .STACK_DEPTH(2)) dut2 (
    .clk(clk), .reset(rst2), .stall(stall2), .cond_in(cond2), .dispatch_addr(disp2),
    .mw_ctrl(mw_ctrl2), .mw_cr(mw_cr2), .mw_inv(mw_inv2), .mw_sel(mw_sel2), .mw_n(mw_n2),
    .ustore_addr(ua2), .ctrl(ctrl2), .active_state(st2), .sp(sp2),
    .stk_ovf(ovf2), .stk_unf(unf2)
  );

  // Microstore models
  logic [2:0] r1_n [128];
  logic [1:0] r1_sel [128];
  logic       r1_inv [128];
  logic [6:0] r1_cr [128];
  logic [2:0] r2_n [16];
  logic [1:0] r2_sel [16];
  logic       r2_inv [16];
  logic [3:0] r2_cr [16];

  function automatic logic [43:0] ctrl_of1(input logic [6:0] a);
    return {12'hC5A, 25'h0F0F0F0, a};
  endfunction

  function automatic logic [7:0] ctrl_of2(input logic [3:0] a);
    return {4'hA, a};
  endfunction

  always_comb begin
    mw_n1    = r1_n[ua1];
    mw_sel1  = r1_sel[ua1];
    mw_inv1  = r1_inv[ua1];
    mw_cr1   = r1_cr[ua1];
    mw_ctrl1 = ctrl_of1(ua1);
    mw_n2    = r2_n[ua2];
    mw_sel2  = r2_sel[ua2];
    mw_inv2  = r2_inv[ua2];
    mw_cr2   = r2_cr[ua2];
    mw_ctrl2 = force2 ? 8'hFF : ctrl_of2(ua2);
  end

  task automatic set1(input int a, input logic [2:0] n, input logic [1:0] sel,
                      input logic inv, input logic [6:0] cr);
    r1_n[a] = n; r1_sel[a] = sel; r1_inv[a] = inv; r1_cr[a] = cr;
  endtask

  task automatic set2(input int a, input logic [2:0] n, input logic [1:0] sel,
                      input logic inv, input logic [3:0] cr);
    r2_n[a] = n; r2_sel[a] = sel; r2_inv[a] = inv; r2_cr[a] = cr;
  endtask

  task automatic clear2();
    for (int a = 0; a < 16; a++) set2(a, 3'd2, 2'd0, 1'b0, 4'd0);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0] cond;
    logic [6:0] disp;
    logic [6:0] st;
    logic [2:0] sp;
    logic       ovf;
    logic       unf;
  } vec_t;

  function automatic vec_t mkv(input logic [3:0] c, input logic [6:0] d, input logic [6:0] s,
                               input logic [2:0] p, input logic o, input logic u);
    vec_t v;
    v.cond = c; v.disp = d; v.st = s; v.sp = p; v.ovf = o; v.unf = u;
    return v;
  endfunction

  vec_t vq[$];

  initial begin
    logic [3:0] e2_st  [7];
    logic [1:0] e2_sp  [7];
    logic       e2_ovf [7];
    logic       e2_unf [7];

    // Program DUT1 microstore: default op is increment.
    for (int a = 0; a < 128; a++) set1(a, 3'd2, 2'd0, 1'b0, 7'd0);
    set1(3,    3'd5, 2'd2, 1'b0, 7'd40);   // conditional call
    set1(5,    3'd4, 2'd0, 1'b0, 7'd9);    // wait on cond0
    set1(9,    3'd3, 2'd1, 1'b1, 7'd20);   // branch on !cond1
    set1(20,   3'd4, 2'd0, 1'b1, 7'd10);   // wait on !cond0
    set1(10,   3'd5, 2'd2, 1'b0, 7'd40);
    set1(40,   3'd6, 2'd0, 1'b0, 7'd0);
    set1(11,   3'd5, 2'd2, 1'b1, 7'd50);
    set1(50,   3'd5, 2'd3, 1'b0, 7'd60);
    set1(60,   3'd5, 2'd3, 1'b0, 7'd70);
    set1(70,   3'd6, 2'd0, 1'b0, 7'd0);
    set1(61,   3'd6, 2'd0, 1'b0, 7'd0);
    set1(51,   3'd6, 2'd0, 1'b0, 7'd0);
    set1(12,   3'd7, 2'd0, 1'b0, 7'd30);
    set1(30,   3'd1, 2'd0, 1'b0, 7'd0);
    set1(7'h22, 3'd7, 2'd0, 1'b0, 7'h10);
    set1(7'h45, 3'd6, 2'd0, 1'b0, 7'd0);

    // DUT2 microstore: three nested calls then three returns.
    clear2();
    set2(1,  3'd5, 2'd0, 1'b1, 4'd4);
    set2(4,  3'd5, 2'd0, 1'b1, 4'd7);
    set2(7,  3'd5, 2'd0, 1'b1, 4'd10);
    set2(10, 3'd6, 2'd0, 1'b0, 4'd0);
    set2(5,  3'd6, 2'd0, 1'b0, 4'd0);
    set2(2,  3'd6, 2'd0, 1'b0, 4'd0);

    //          cond   disp   state  sp ovf unf
    vq.push_back(mkv(4'h0, 7'h00, 7'd1,  3'd0, 0, 0));
    vq.push_back(mkv(4'h0, 7'h00, 7'd2,  3'd0, 0, 0));
    vq.push_back(mkv(4'h0, 7'h00, 7'd3,  3'd0, 0, 0));
    vq.push_back(mkv(4'h0, 7'h00, 7'd4,  3'd0, 0, 0));   // call not taken
    vq.push_back(mkv(4'h0, 7'h00, 7'd5,  3'd0, 0, 0));
    vq.push_back(mkv(4'h0, 7'h00, 7'd5,  3'd0, 0, 0));   // wait loop
    vq.push_back(mkv(4'h0, 7'h00, 7'd5,  3'd0, 0, 0));
    vq.push_back(mkv(4'h0, 7'h00, 7'd5,  3'd0, 0, 0));
    vq.push_back(mkv(4'h1, 7'h00, 7'd9,  3'd0, 0, 0));
    vq.push_back(mkv(4'h0, 7'h00, 7'd20, 3'd0, 0, 0));   // inverted branch
    vq.push_back(mkv(4'h1, 7'h00, 7'd20, 3'd0, 0, 0));   // inverted wait
    vq.push_back(mkv(4'h1, 7'h00, 7'd20, 3'd0, 0, 0));
    vq.push_back(mkv(4'h0, 7'h00, 7'd10, 3'd0, 0, 0));
    vq.push_back(mkv(4'h4, 7'h00, 7'd40, 3'd1, 0, 0));   // call
    vq.push_back(mkv(4'h0, 7'h00, 7'd11, 3'd0, 0, 0));   // return
    vq.push_back(mkv(4'h0, 7'h00, 7'd50, 3'd1, 0, 0));   // nested calls
    vq.push_back(mkv(4'h8, 7'h00, 7'd60, 3'd2, 0, 0));
    vq.push_back(mkv(4'h8, 7'h00, 7'd70, 3'd3, 0, 0));
    vq.push_back(mkv(4'h0, 7'h00, 7'd61, 3'd2, 0, 0));
    vq.push_back(mkv(4'h0, 7'h00, 7'd51, 3'd1, 0, 0));
    vq.push_back(mkv(4'h0, 7'h00, 7'd12, 3'd0, 0, 0));
    vq.push_back(mkv(4'h0, 7'h22, 7'd30, 3'd0, 0, 0));   // dbr, sts=0 -> cr
    vq.push_back(mkv(4'h0, 7'h22, 7'h22, 3'd0, 0, 0));   // dispatch
    vq.push_back(mkv(4'h1, 7'h45, 7'h45, 3'd0, 0, 0));   // dbr, sts=1 -> dispatch
    vq.push_back(mkv(4'h0, 7'h00, 7'd1,  3'd0, 0, 1));   // underflow -> fetch
    vq.push_back(mkv(4'h0, 7'h00, 7'd2,  3'd0, 0, 1));
    vq.push_back(mkv(4'h0, 7'h00, 7'd3,  3'd0, 0, 1));
    vq.push_back(mkv(4'h4, 7'h00, 7'd40, 3'd1, 0, 1));   // call taken from 3
    vq.push_back(mkv(4'h0, 7'h00, 7'd4,  3'd0, 0, 1));
    vq.push_back(mkv(4'h0, 7'h00, 7'd5,  3'd0, 0, 1));
    vq.push_back(mkv(4'h1, 7'h00, 7'd9,  3'd0, 0, 1));
    vq.push_back(mkv(4'h0, 7'h00, 7'd20, 3'd0, 0, 1));
    vq.push_back(mkv(4'h0, 7'h00, 7'd10, 3'd0, 0, 1));
    vq.push_back(mkv(4'h4, 7'h00, 7'd40, 3'd1, 0, 1));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst state", st1, 0);
    chk("rst ctrl", ctrl1, 0);
    chk("rst sp", sp1, 0);
    chk("rst ovf", ovf1, 0);
    chk("rst unf", unf1, 0);
    chk("rst ustore_addr", ua1, 1);
    chk("rst2 state", st2, 0);
    chk("rst2 ustore_addr", ua2, 1);

    @(negedge clk);
    rst1 = 1'b1;
    foreach (vq[i]) begin
      cond1 = vq[i].cond;
      disp1 = vq[i].disp;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d state", i), st1, vq[i].st);
      chk($sformatf("v%0d ctrl", i), ctrl1, ctrl_of1(vq[i].st));
      chk($sformatf("v%0d sp", i), sp1, vq[i].sp);
      chk($sformatf("v%0d ovf", i), ovf1, vq[i].ovf);
      chk($sformatf("v%0d unf", i), unf1, vq[i].unf);
      @(negedge clk);
    end

    // Mid-call async reset (state 40, return address 11 pending)
    cond1 = '0;
    #1 chk("midcall ret addr", ua1, 11);
    #1 rst1 = 1'b0;
    #1;
    chk("midcall rst sp", sp1, 0);
    chk("midcall rst state", st1, 0);
    chk("midcall rst ustore_addr", ua1, 1);
    chk("midcall rst unf", unf1, 0);
    @(negedge clk);
    rst1 = 1'b1;
    @(posedge clk);
    #1;
    chk("post rst state", st1, 1);
    chk("post rst sp", sp1, 0);

    // DUT2: overflow then underflow
    e2_st  = '{4'd1, 4'd4, 4'd7, 4'd10, 4'd5, 4'd2, 4'd1};
    e2_sp  = '{2'd0, 2'd1, 2'd2, 2'd2,  2'd1, 2'd0, 2'd0};
    e2_ovf = '{0, 0, 0, 1, 1, 1, 1};
    e2_unf = '{0, 0, 0, 0, 0, 0, 1};
    @(negedge clk);
    rst2 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("ou%0d state", i), st2, e2_st[i]);
      chk($sformatf("ou%0d sp", i), sp2, e2_sp[i]);
      chk($sformatf("ou%0d ovf", i), ovf2, e2_ovf[i]);
      chk($sformatf("ou%0d unf", i), unf2, e2_unf[i]);
      chk($sformatf("ou%0d ctrl", i), ctrl2, ctrl_of2(e2_st[i]));
    end

    // DUT2: wrap 15 -> 0 then stall on a call
    @(negedge clk);
    rst2 = 1'b0;
    clear2();
    set2(1,  3'd3, 2'd0, 1'b1, 4'd15);
    set2(15, 3'd2, 2'd0, 1'b0, 4'd0);
    set2(0,  3'd5, 2'd0, 1'b1, 4'd6);
    #1 chk("rst2b flags", {ovf2, unf2}, 0);
    @(negedge clk);
    rst2 = 1'b1;
    @(posedge clk); #1 chk("wrap s1", st2, 1);
    @(posedge clk); #1 chk("wrap s15", st2, 15);
    @(posedge clk); #1 chk("wrap s0", st2, 0);
    @(negedge clk);
    chk("pre-stall ustore_addr", ua2, 6);
    stall2 = 1'b1;
    force2 = 1'b1;
    #1 chk("stall ustore_addr", ua2, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d state", i), st2, 0);
      chk($sformatf("stall%0d sp", i), sp2, 0);
      chk($sformatf("stall%0d ctrl", i), ctrl2, ctrl_of2(0));
    end
    @(negedge clk);
    stall2 = 1'b0;
    force2 = 1'b0;
    @(posedge clk);
    #1;
    chk("unstall state", st2, 6);
    chk("unstall sp", sp2, 1);
    chk("unstall ctrl", ctrl2, ctrl_of2(6));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
